// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : shared UART receive types, parity modes and helpers     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int c_MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_t;

  // Data field is sized for the widest frame; narrower frames leave the top bits zero.
  typedef struct packed {
    logic [c_MAX_DATA_BITS-1:0] data;
    logic                       perr;
    logic                       ferr;
  } rx_frame_t;

  function automatic rx_frame_t frame_pack(input logic [c_MAX_DATA_BITS-1:0] data,
                                           input logic perr, input logic ferr);
    rx_frame_t f;
    f.data = data;
    f.perr = perr;
    f.ferr = ferr;
    return f;
  endfunction

  function automatic int bit_clocks(input int half_bit);
    return 2 * half_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_fifo : synchronous first-word-fall-through FIFO            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_CW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push & (~full | w_do_pop);
  assign rdata     = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + c_AW'(1);
      r_count <= r_count + c_CW'(w_do_push) - c_CW'(w_do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_param : parametrised UART receiver with glitch/break       |
// |                 handling and a receive FIFO. Rev 1.0               |
// +--------------------------------------------------------------------+
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            rxd,
  output logic [DATA_BITS-1:0]            rdata,
  output logic                            rperr,
  output logic                            rferr,
  output logic                            rvalid,
  input  logic                            rready,
  output logic                            overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int                c_BIT       = bit_clocks(CLK_PER_HALF_BIT);
  localparam int                c_CNT_W     = $clog2(c_BIT);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_BIT - 1);
  localparam logic [3:0]        c_IDX_LAST  = 4'(DATA_BITS - 1);
  localparam logic              c_STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic              c_PAR_EXP   = (PARITY == PAR_ODD);

  logic [1:0]                 r_sync;
  rx_state_t                  r_state, w_state_nxt;
  logic [c_CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic [3:0]                 r_idx, w_idx_nxt;
  logic                       r_stop_idx, w_stop_idx_nxt;
  logic [c_MAX_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                       r_perr, w_perr_nxt;
  logic                       r_ferr, w_ferr_nxt;
  logic                       r_push, w_push_nxt;
  rx_frame_t                  r_frame;
  rx_frame_t                  w_head;
  logic                       w_rxs, w_tick, w_pop, w_full, w_empty;
  logic                       w_head_unused;

  assign w_rxs  = r_sync[1];
  assign w_tick = (r_cnt == c_BIT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rxd};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + c_CNT_W'(1);
    w_idx_nxt      = r_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_shift_nxt    = r_shift;
    w_perr_nxt     = r_perr;
    w_ferr_nxt     = r_ferr;
    w_push_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_rxs) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == c_HALF_LAST) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DATA;
            w_idx_nxt   = '0;
            w_shift_nxt = '0;
            w_perr_nxt  = 1'b0;
            w_ferr_nxt  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_cnt_nxt          = '0;
          w_shift_nxt[r_idx] = w_rxs;
          w_stop_idx_nxt     = 1'b0;
          if (r_idx == c_IDX_LAST) w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          else                     w_idx_nxt   = r_idx + 4'd1;
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = ((^r_shift) ^ w_rxs) != c_PAR_EXP;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!w_rxs) w_ferr_nxt = 1'b1;
          if (r_stop_idx == c_STOP_LAST) begin
            w_push_nxt  = 1'b1;
            // A low final stop bit may be a break; wait for idle before rearming.
            w_state_nxt = w_rxs ? ST_IDLE : ST_BREAK_WAIT;
          end else begin
            w_stop_idx_nxt = 1'b1;
          end
        end
      end
      ST_BREAK_WAIT: begin
        w_cnt_nxt = '0;
        if (w_rxs) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_push     <= 1'b0;
      r_frame    <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_perr     <= w_perr_nxt;
      r_ferr     <= w_ferr_nxt;
      r_push     <= w_push_nxt;
      if (w_push_nxt) r_frame <= frame_pack(w_shift_nxt, w_perr_nxt, w_ferr_nxt);
    end
  end

  uart_rx_fifo #(
    .WIDTH ($bits(rx_frame_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (r_push),
    .wdata (r_frame),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  assign rvalid        = ~w_empty;
  assign w_pop         = rvalid & rready;
  assign overrun       = r_push & w_full & ~w_pop;
  assign rdata         = w_head.data[DATA_BITS-1:0];
  assign rperr         = w_head.perr;
  assign rferr         = w_head.ferr;
  assign w_head_unused = ^w_head.data;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for uart_rx_param: three instances (8N1, 8E1, 7N2), half bit = 4 clocks.
module tb_uart_rx_param;

  localparam int BIT = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rxd_v [3] = '{1'b1, 1'b1, 1'b1};
  logic rdy_v [3] = '{1'b0, 1'b0, 1'b0};

  logic [7:0] rdata_a, rdata_p;
  logic [6:0] rdata_s;
  logic [8:0] od [3];
  logic       pe [3], fe [3], rv [3], ov [3];
  logic [2:0] cnt [3];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_PER_HALF_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rstn(rstn), .rxd(rxd_v[0]), .rdata(rdata_a), .rperr(pe[0]), .rferr(fe[0]),
    .rvalid(rv[0]), .rready(rdy_v[0]), .overrun(ov[0]), .fifo_count(cnt[0]));
  uart_rx_param #(.CLK_PER_HALF_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
    .clk(clk), .rstn(rstn), .rxd(rxd_v[1]), .rdata(rdata_p), .rperr(pe[1]), .rferr(fe[1]),
    .rvalid(rv[1]), .rready(rdy_v[1]), .overrun(ov[1]), .fifo_count(cnt[1]));
  uart_rx_param #(.CLK_PER_HALF_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .rstn(rstn), .rxd(rxd_v[2]), .rdata(rdata_s), .rperr(pe[2]), .rferr(fe[2]),
    .rvalid(rv[2]), .rready(rdy_v[2]), .overrun(ov[2]), .fifo_count(cnt[2]));

  assign od[0] = {1'b0, rdata_a};
  assign od[1] = {1'b0, rdata_p};
  assign od[2] = {2'b00, rdata_s};

  int nbits_c [3] = '{8, 8, 7};
  int haspar_c[3] = '{0, 1, 0};
  int nstop_c [3] = '{1, 1, 2};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int push_t[$];
  logic [2:0] prev_cnt_a = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe dut_a: overrun pulses and the cycle of every occupancy increase.
  always @(negedge clk) begin
    if (ov[0]) ovr_cnt = ovr_cnt + 1;
    if (cnt[0] > prev_cnt_a) push_t.push_back(cyc);
    prev_cnt_a = cnt[0];
  end

  typedef struct {
    int         d;
    logic [8:0] data;
    logic       par;
    logic [1:0] stops;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic put_bit(input int d, input logic b);
    rxd_v[d] = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input logic par, input logic [1:0] stops);
    put_bit(d, 1'b0);
    for (int i = 0; i < nbits_c[d]; i++) put_bit(d, data[i]);
    if (haspar_c[d] != 0) put_bit(d, par);
    for (int i = 0; i < nstop_c[d]; i++) put_bit(d, stops[i]);
    rxd_v[d] = 1'b1;
  endtask

  task automatic pop(input int d);
    rdy_v[d] = 1'b1;
    @(negedge clk);
    rdy_v[d] = 1'b0;
  endtask

  task automatic check_head(input string nm, input int d, input logic [8:0] ed, input logic ep, input logic ef);
    chk({nm, ".rvalid"}, int'(rv[d]), 1);
    chk({nm, ".rdata"},  int'(od[d]), int'(ed));
    chk({nm, ".rperr"},  int'(pe[d]), int'(ep));
    chk({nm, ".rferr"},  int'(fe[d]), int'(ef));
  endtask

  initial begin
    int n0;
    int ov0;
    vecs[0]  = '{0, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h0A3, 1'b0, 2'b11, 9'h0A3, 1'b0, 1'b0};
    vecs[2]  = '{0, 9'h000, 1'b0, 2'b10, 9'h000, 1'b0, 1'b1};
    vecs[3]  = '{1, 9'h007, 1'b0, 2'b11, 9'h007, 1'b1, 1'b0};
    vecs[4]  = '{1, 9'h007, 1'b1, 2'b11, 9'h007, 1'b0, 1'b0};
    vecs[5]  = '{1, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
    vecs[6]  = '{1, 9'h080, 1'b0, 2'b11, 9'h080, 1'b1, 1'b0};
    vecs[7]  = '{1, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1};
    vecs[8]  = '{2, 9'h02A, 1'b0, 2'b01, 9'h02A, 1'b0, 1'b1};
    vecs[9]  = '{2, 9'h015, 1'b0, 2'b11, 9'h015, 1'b0, 1'b0};
    vecs[10] = '{2, 9'h07F, 1'b0, 2'b10, 9'h07F, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset.rvalid", int'(rv[d]), 0);
      chk("reset.count", int'(cnt[d]), 0);
      chk("reset.overrun", int'(ov[d]), 0);
      chk("reset.rdata", int'(od[d]), 0);
    end
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven single frames
    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i].d, vecs[i].data, vecs[i].par, vecs[i].stops);
      repeat (16) @(negedge clk);
      check_head($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr);
      pop(vecs[i].d);
      chk($sformatf("vec%0d.empty", i), int'(rv[vecs[i].d]), 0);
    end

    // Back-to-back frames: pushes one frame time (10 bits = 80 clocks) apart
    n0 = push_t.size();
    send_frame(0, 9'h055, 1'b0, 2'b11);
    send_frame(0, 9'h0A3, 1'b0, 2'b11);
    repeat (16) @(negedge clk);
    chk("b2b.pushes", push_t.size() - n0, 2);
    if (push_t.size() - n0 == 2) chk("b2b.spacing", push_t[n0+1] - push_t[n0], 80);
    check_head("b2b0", 0, 9'h055, 1'b0, 1'b0);
    pop(0);
    check_head("b2b1", 0, 9'h0A3, 1'b0, 1'b0);
    pop(0);

    // Start-bit glitch of 3 clocks
    rxd_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    rxd_v[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch.count", int'(cnt[0]), 0);
    chk("glitch.rvalid", int'(rv[0]), 0);

    // Break: line low 30 bit times yields exactly one framing-error frame
    rxd_v[0] = 1'b0;
    repeat (30 * BIT) @(negedge clk);
    rxd_v[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("break.count", int'(cnt[0]), 1);
    check_head("break", 0, 9'h000, 1'b0, 1'b1);
    pop(0);
    repeat (100) @(negedge clk);
    chk("break.after", int'(cnt[0]), 0);
    send_frame(0, 9'h041, 1'b0, 2'b11);
    repeat (16) @(negedge clk);
    check_head("post_break", 0, 9'h041, 1'b0, 1'b0);
    pop(0);

    // Overrun: five frames into a depth-4 FIFO with no reader
    ov0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 1'b0, 2'b11);
    repeat (16) @(negedge clk);
    chk("ovr.count", int'(cnt[0]), 4);
    chk("ovr.pulses", ovr_cnt - ov0, 1);
    for (int i = 1; i <= 4; i++) begin
      check_head($sformatf("ovr_pop%0d", i), 0, 9'(i), 1'b0, 1'b0);
      pop(0);
    end
    chk("ovr.drained", int'(cnt[0]), 0);

    // 7N2: second stop bit low, then reset during the next frame
    send_frame(2, 9'h02A, 1'b0, 2'b01);
    repeat (16) @(negedge clk);
    chk("rst.pre_count", int'(cnt[2]), 1);
    check_head("rst.pre", 2, 9'h02A, 1'b0, 1'b1);
    put_bit(2, 1'b0);
    put_bit(2, 1'b1);
    put_bit(2, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("rst.async_rvalid", int'(rv[2]), 0);
    chk("rst.async_count", int'(cnt[2]), 0);
    rxd_v[2] = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst.idle_count", int'(cnt[2]), 0);
    send_frame(2, 9'h015, 1'b0, 2'b11);
    repeat (16) @(negedge clk);
    check_head("rst.post", 2, 9'h015, 1'b0, 1'b0);
    pop(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
